// File: rtl/expands_ctrl_if.sv
// expands_ctrl_if: bus bundle between the ExpandS sequencer, the Rho_prime
// buffer, the shared SHAKE256 core and the half-byte rejection sampler.
// master = sequencer side, slave = memory/core/sampler side.
`timescale 1ns/1ps
interface expands_ctrl_if #(
    parameter int DLEN = 64,
    parameter int HLEN = 3
);
    logic [HLEN-1:0] Rho_prime_raddr;
    logic [DLEN-1:0] Rho_prime_dout;
    logic            shake_init;
    logic            shake_absorb_valid;
    logic [DLEN-1:0] shake_absorb_data;
    logic            shake_absorb_last;
    logic            shake_absorb_ready;
    logic            shake_squeeze_req;
    logic            shake_block_valid;
    logic            sample_in_ready;
    logic            sample_block_done;
    logic            sample_poly_done;

    modport master (
        output Rho_prime_raddr,
        input  Rho_prime_dout,
        output shake_init,
        output shake_absorb_valid,
        output shake_absorb_data,
        output shake_absorb_last,
        input  shake_absorb_ready,
        output shake_squeeze_req,
        input  shake_block_valid,
        output sample_in_ready,
        input  sample_block_done,
        input  sample_poly_done
    );

    modport slave (
        input  Rho_prime_raddr,
        output Rho_prime_dout,
        input  shake_init,
        input  shake_absorb_valid,
        input  shake_absorb_data,
        input  shake_absorb_last,
        output shake_absorb_ready,
        input  shake_squeeze_req,
        output shake_block_valid,
        input  sample_in_ready,
        output sample_block_done,
        output sample_poly_done
    );
endinterface

// File: rtl/expands_ctrl.sv
// expands_ctrl: ExpandS sequencer. For each polynomial it restarts SHAKE256,
// absorbs rho' (8 words) plus the 16-bit LE nonce with the 0x1F domain pad,
// then squeezes 136-byte blocks into the rejection sampler until it reports
// a full polynomial. All outputs are registered from the next state.
// Optional build macro: EXPANDS_CTRL_STATS_EN adds the blk_cnt output
// (squeezed blocks accepted during the current run, saturating).
// Rho_prime_dout is taken at the clock edge that closes the RD cycle.
`timescale 1ns/1ps
module expands_ctrl #(
    parameter int DLEN  = 64,
    parameter int HLEN  = 3,
    parameter int NPOLY = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            poly_idx,
    expands_ctrl_if.master        bus
`ifdef EXPANDS_CTRL_STATS_EN
    ,
    output logic [15:0]           blk_cnt
`endif
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INIT     = 4'd1;
    localparam logic [3:0] S_RD       = 4'd2;
    localparam logic [3:0] S_ABSORB   = 4'd3;
    localparam logic [3:0] S_NONCE    = 4'd4;
    localparam logic [3:0] S_SQZ      = 4'd5;
    localparam logic [3:0] S_WAIT_BLK = 4'd6;
    localparam logic [3:0] S_SAMPLE   = 4'd7;
    localparam logic [3:0] S_NEXT     = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    localparam logic [HLEN-1:0] W_LAST = {HLEN{1'b1}};
    localparam logic [HLEN-1:0] W_ONE  = {{(HLEN-1){1'b0}}, 1'b1};
    localparam logic [3:0]      P_LAST = 4'(NPOLY - 1);

    logic [3:0]      state_q, state_d;
    logic [HLEN-1:0] w_q, w_d;
    logic [3:0]      poly_q, poly_d;
    logic [HLEN-1:0] raddr_q;
    logic [DLEN-1:0] data_q;
    logic            init_q, valid_q, last_q, sqz_q, rdy_q, busy_q, done_q;
    logic [DLEN-1:0] nonce_word_s;

    // Nonce word: bytes 64..65 carry the LE nonce, byte 66 the 0x1F pad.
    assign nonce_word_s = {{(DLEN-24){1'b0}}, 8'h1F, 8'h00, 4'h0, poly_q};

    // Next-state, word-counter and polynomial-index logic.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        poly_d  = poly_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    poly_d  = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                w_d     = {HLEN{1'b0}};
                state_d = S_RD;
            end
            S_RD: state_d = S_ABSORB;
            S_ABSORB: begin
                if (bus.shake_absorb_ready) begin
                    if (w_q == W_LAST) begin
                        state_d = S_NONCE;
                    end else begin
                        w_d     = w_q + W_ONE;
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_ABSORB;
                end
            end
            S_NONCE: begin
                if (bus.shake_absorb_ready) begin
                    state_d = S_SQZ;
                end else begin
                    state_d = S_NONCE;
                end
            end
            S_SQZ: state_d = S_WAIT_BLK;
            S_WAIT_BLK: begin
                if (bus.shake_block_valid) begin
                    state_d = S_SAMPLE;
                end else begin
                    state_d = S_WAIT_BLK;
                end
            end
            S_SAMPLE: begin
                // A finished polynomial wins; leftover block bytes are dropped.
                if (bus.sample_poly_done) begin
                    state_d = S_NEXT;
                end else if (bus.sample_block_done) begin
                    state_d = S_SQZ;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_NEXT: begin
                if (poly_q == P_LAST) begin
                    state_d = S_DONE;
                end else begin
                    poly_d  = poly_q + 4'd1;
                    state_d = S_INIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            w_q     <= {HLEN{1'b0}};
            poly_q  <= 4'd0;
            raddr_q <= {HLEN{1'b0}};
            data_q  <= {DLEN{1'b0}};
            init_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sqz_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            poly_q  <= poly_d;
            init_q  <= (state_d == S_INIT);
            valid_q <= (state_d == S_ABSORB) || (state_d == S_NONCE);
            last_q  <= (state_d == S_NONCE);
            sqz_q   <= (state_d == S_SQZ);
            rdy_q   <= (state_d == S_SAMPLE);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q  <= (state_d == S_DONE);
            if (state_d == S_RD) begin
                raddr_q <= w_d;
            end
            // Holding register only moves on RD exit or NONCE entry, so the
            // absorb word stays stable while the core stalls.
            if (state_q == S_RD) begin
                data_q <= bus.Rho_prime_dout;
            end else if ((state_d == S_NONCE) && (state_q != S_NONCE)) begin
                data_q <= nonce_word_s;
            end
        end
    end

`ifdef EXPANDS_CTRL_STATS_EN
    logic [15:0] blk_cnt_q;

    // Count squeezed blocks accepted in WAIT_BLK, saturating, cleared on start.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt_q <= 16'h0000;
        end else if ((state_q == S_IDLE) && start) begin
            blk_cnt_q <= 16'h0000;
        end else if ((state_q == S_WAIT_BLK) && bus.shake_block_valid &&
                     (blk_cnt_q != 16'hFFFF)) begin
            blk_cnt_q <= blk_cnt_q + 16'h0001;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign poly_idx               = poly_q;
    assign bus.Rho_prime_raddr    = raddr_q;
    assign bus.shake_init         = init_q;
    assign bus.shake_absorb_valid = valid_q;
    assign bus.shake_absorb_data  = data_q;
    assign bus.shake_absorb_last  = last_q;
    assign bus.shake_squeeze_req  = sqz_q;
    assign bus.sample_in_ready    = rdy_q;

endmodule

// File: tb/tb_expands_ctrl.sv
// tb_expands_ctrl: scoreboard bench for expands_ctrl. The main process issues
// runs and pushes the expected absorb words and INIT poly indices; a monitor
// pops and compares on every accepted absorb word / INIT pulse. A responder
// process models the Rho_prime buffer, SHAKE core and sampler.
`timescale 1ns/1ps
module tb_expands_ctrl;
    localparam int NPOLY = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] poly_idx;
`ifdef EXPANDS_CTRL_STATS_EN
    logic [15:0] blk_cnt;
`endif

    expands_ctrl_if #(.DLEN(64), .HLEN(3)) bus ();

    expands_ctrl #(.DLEN(64), .HLEN(3), .NPOLY(NPOLY)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .poly_idx (poly_idx),
        .bus      (bus)
`ifdef EXPANDS_CTRL_STATS_EN
        ,
        .blk_cnt  (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] mem [8];
    assign bus.Rho_prime_dout = mem[bus.Rho_prime_raddr];

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];
    logic [3:0]  init_q[$];
    int init_cnt, sqz_cnt, done_cnt, cyc_n, t_init0, t_sqz0;
    int need [16];
    bit both [16];
    int rdy_mode;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        init_cnt = 0; sqz_cnt = 0; done_cnt = 0; t_init0 = -1; t_sqz0 = -1;
    endtask

    // Expected absorb stream: 8 rho' words then the nonce word, per polynomial.
    task automatic push_run();
        for (int p = 0; p < NPOLY; p++) begin
            init_q.push_back(4'(p));
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, mem[i]});
            exp_q.push_back({1'b1, 64'h00000000001F0000 | 64'(p)});
        end
    endtask

    task automatic wait_done(input string nm);
        int k;
        for (k = 0; k < 5000; k++) begin
            tick();
            if (done) break;
        end
        chk({nm, "_done_seen"}, 64'(k < 5000), 64'd1);
    endtask

    // Monitor: scoreboard pops, stall stability, pulse counters.
    initial begin
        logic        prev_stall;
        logic [64:0] prev_word;
        logic [64:0] e;
        prev_stall = 1'b0;
        prev_word  = '0;
        cyc_n      = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.shake_absorb_valid), 64'd1);
                    chk("stall_data", 64'(bus.shake_absorb_data), prev_word[63:0]);
                    chk("stall_last", 64'(bus.shake_absorb_last), 64'(prev_word[64]));
                end
                if (bus.shake_absorb_valid && bus.shake_absorb_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("absorb_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("absorb_data", bus.shake_absorb_data, e[63:0]);
                        chk("absorb_last", 64'(bus.shake_absorb_last), 64'(e[64]));
                    end
                end
                if (bus.shake_init) begin
                    init_cnt++;
                    if (t_init0 < 0) t_init0 = cyc_n;
                    if (init_q.size() == 0) begin
                        chk("init_unexpected", 64'd1, 64'd0);
                    end else begin
                        chk("init_poly_idx", 64'(poly_idx), 64'(init_q.pop_front()));
                    end
                end
                if (bus.shake_squeeze_req) begin
                    sqz_cnt++;
                    if (t_sqz0 < 0) t_sqz0 = cyc_n;
                end
                if (done) done_cnt++;
                prev_stall = bus.shake_absorb_valid && !bus.shake_absorb_ready;
                prev_word  = {bus.shake_absorb_last, bus.shake_absorb_data};
            end
        end
    end

    // Responder: absorb-ready pattern, block delivery and sampler behaviour.
    initial begin
        int blk_wait, smp_cyc, blocks_used, rc;
        blk_wait = 0; smp_cyc = 0; blocks_used = 0; rc = 0;
        bus.shake_absorb_ready = 1'b1;
        bus.shake_block_valid  = 1'b0;
        bus.sample_block_done  = 1'b0;
        bus.sample_poly_done   = 1'b0;
        forever begin
            tick();
            rc++;
            bus.shake_block_valid = 1'b0;
            bus.sample_block_done = 1'b0;
            bus.sample_poly_done  = 1'b0;
            bus.shake_absorb_ready = (rdy_mode == 0) ? 1'b1 : ((rc % 3) == 0);
            if (reset) begin
                blk_wait = 0; smp_cyc = 0; blocks_used = 0;
            end else begin
                if (bus.shake_squeeze_req) begin
                    blk_wait = 2;
                end else if (blk_wait > 0) begin
                    blk_wait--;
                    if (blk_wait == 0) bus.shake_block_valid = 1'b1;
                end
                if (bus.sample_in_ready) begin
                    smp_cyc++;
                    if (smp_cyc == 3) begin
                        if (blocks_used + 1 < need[poly_idx]) begin
                            bus.sample_block_done = 1'b1;
                            blocks_used++;
                        end else begin
                            bus.sample_poly_done = 1'b1;
                            if (both[poly_idx]) bus.sample_block_done = 1'b1;
                            blocks_used = 0;
                        end
                    end
                end else begin
                    smp_cyc = 0;
                end
            end
        end
    end

    // Main sequence.
    initial begin
        int k;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) mem[i][8*j +: 8] = 8'(8*i + j);
        for (int i = 0; i < 16; i++) begin need[i] = 1; both[i] = 1'b0; end
        rdy_mode = 0;
        reset = 1'b1;
        start = 1'b0;
        clear_counts();
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_init", 64'(bus.shake_init), 64'd0);
        chk("rst_valid", 64'(bus.shake_absorb_valid), 64'd0);
        chk("rst_data", bus.shake_absorb_data, 64'd0);
        chk("rst_last", 64'(bus.shake_absorb_last), 64'd0);
        chk("rst_sqz", 64'(bus.shake_squeeze_req), 64'd0);
        chk("rst_sready", 64'(bus.sample_in_ready), 64'd0);
        chk("rst_raddr", 64'(bus.Rho_prime_raddr), 64'd0);
        chk("rst_poly", 64'(poly_idx), 64'd0);
`ifdef EXPANDS_CTRL_STATS_EN
        chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
`endif
        tick();

        // Run A: ready high, one block per polynomial.
        clear_counts();
        push_run();
        start = 1'b1; tick(); start = 1'b0;
        chk("a_busy_after_start", 64'(busy), 64'd1);
        chk("a_init_first", 64'(bus.shake_init), 64'd1);
        repeat (30) tick();
        start = 1'b1; tick(); start = 1'b0;   // ignored while busy
        wait_done("a");
        chk("a_busy_in_done", 64'(busy), 64'd0);
        start = 1'b1; tick(); start = 1'b0;   // start in DONE cycle: ignored
        chk("a_done_width", 64'(done), 64'd0);
        repeat (5) tick();
        chk("a_busy_after", 64'(busy), 64'd0);
        chk("a_init_cnt", 64'(init_cnt), 64'(NPOLY));
        chk("a_sqz_cnt", 64'(sqz_cnt), 64'(NPOLY));
        chk("a_done_cnt", 64'(done_cnt), 64'd1);
        chk("a_poly_final", 64'(poly_idx), 64'(NPOLY - 1));
        chk("a_init_to_sqz", 64'(t_sqz0 - t_init0), 64'd18);
        chk("a_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef EXPANDS_CTRL_STATS_EN
        chk("a_blk_cnt", 64'(blk_cnt), 64'(NPOLY));
`endif

        // Run B: ready 1-in-3, poly 0 takes 3 blocks, poly 1 both dones at once.
        rdy_mode = 1; need[0] = 3; both[1] = 1'b1;
        clear_counts();
        push_run();
        start = 1'b1; tick(); start = 1'b0;
        wait_done("b");
        repeat (3) tick();
        chk("b_init_cnt", 64'(init_cnt), 64'(NPOLY));
        chk("b_sqz_cnt", 64'(sqz_cnt), 64'(NPOLY + 2));
        chk("b_done_cnt", 64'(done_cnt), 64'd1);
        chk("b_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef EXPANDS_CTRL_STATS_EN
        chk("b_blk_cnt", 64'(blk_cnt), 64'd13);
`endif

        // Run C: reset while waiting for a block of poly 5, then a fresh run.
        rdy_mode = 0; need[0] = 1; both[1] = 1'b0;
        clear_counts();
        push_run();
        start = 1'b1; tick(); start = 1'b0;
        for (k = 0; k < 2000; k++) begin
            tick();
            if (bus.shake_squeeze_req && (poly_idx == 4'd5)) break;
        end
        chk("c_reached_poly5", 64'(k < 2000), 64'd1);
        tick();                       // now in WAIT_BLK
        reset = 1'b1;
        tick();
        chk("c_rst_busy", 64'(busy), 64'd0);
        chk("c_rst_poly", 64'(poly_idx), 64'd0);
        chk("c_rst_sready", 64'(bus.sample_in_ready), 64'd0);
        chk("c_rst_sqz", 64'(bus.shake_squeeze_req), 64'd0);
        chk("c_rst_valid", 64'(bus.shake_absorb_valid), 64'd0);
        chk("c_rst_raddr", 64'(bus.Rho_prime_raddr), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        init_q.delete();
        repeat (5) tick();
        chk("c_no_done", 64'(done_cnt), 64'd0);
        chk("c_idle_busy", 64'(busy), 64'd0);
        clear_counts();
        push_run();
        start = 1'b1; tick(); start = 1'b0;
        chk("c_restart_poly", 64'(poly_idx), 64'd0);
        wait_done("c");
        repeat (3) tick();
        chk("c_init_cnt", 64'(init_cnt), 64'(NPOLY));
        chk("c_done_cnt", 64'(done_cnt), 64'd1);
        chk("c_poly_final", 64'(poly_idx), 64'(NPOLY - 1));
        chk("c_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/expands_ctrl.md
# expands_ctrl

Sequencer for the ML-DSA ExpandS secret-vector sampler. For each of NPOLY polynomials it restarts the SHAKE256 core, absorbs rho' (64 bytes, read from the Rho_prime buffer) plus a 16-bit little-endian nonce, then requests 136-byte squeeze blocks and hands them to the half-byte rejection sampler until that sampler reports 256 coefficients. It sits between the top-level key-generation FSM, the Rho_prime memory, the shared Keccak core and the ExpandS sampler datapath.

## Interface
- DLEN, 64, Rho_prime word width and absorb word width
- HLEN, 3, Rho_prime address width (8 words = 64 bytes)
- NPOLY, 11, polynomials to generate (l+k; legal 1..15)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a full ExpandS run; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse when all NPOLY polynomials are complete
- Rho_prime_raddr  out  HLEN  Rho_prime read address
- Rho_prime_dout  in  DLEN  read data, valid one cycle after address
- shake_init  out  1  one-cycle pulse; clears the Keccak state
- shake_absorb_valid  out  1  absorb word valid
- shake_absorb_data  out  DLEN  absorb word, byte 0 in bits [7:0]
- shake_absorb_last  out  1  marks final message word; core applies 0x80 at byte 135
- shake_absorb_ready  in  1  core accepts word when valid & ready
- shake_squeeze_req  out  1  one-cycle pulse requesting the next 136-byte block
- shake_block_valid  in  1  pulse; shake_in now holds a fresh block
- sample_in_ready  out  1  level; block available to the sampler
- sample_block_done  in  1  pulse; sampler consumed all 136 bytes
- sample_poly_done  in  1  pulse; current polynomial has 256 coefficients
- poly_idx  out  4  current polynomial index (= nonce)

## Operation
- States: IDLE, INIT, RD, ABSORB, NONCE, SQZ, WAIT_BLK, SAMPLE, NEXT, DONE.
- IDLE: start -> INIT; poly_idx <= 0.
- INIT: shake_init=1 for one cycle, word counter w <= 0 -> RD.
- RD: drive Rho_prime_raddr = w; next cycle -> ABSORB with data captured from Rho_prime_dout into a holding register.
- ABSORB: shake_absorb_valid=1, data = holding register; on ready: w==7 -> NONCE, else w<=w+1, -> RD. Data held stable while ready low.
- NONCE: data = {40'h0, 8'h1F, 8'h00, 4'h0, poly_idx} (bytes 64..65 nonce LE, byte 66 = 0x1F domain pad), last=1; on ready -> SQZ.
- SQZ: shake_squeeze_req pulse -> WAIT_BLK.
- WAIT_BLK: on shake_block_valid -> SAMPLE.
- SAMPLE: sample_in_ready=1. sample_poly_done -> NEXT (takes precedence over a simultaneous sample_block_done; remaining bytes discarded). sample_block_done alone -> SQZ.
- NEXT: poly_idx == NPOLY-1 -> DONE; else poly_idx <= poly_idx+1, -> INIT.
- DONE: done=1 one cycle -> IDLE. poly_idx holds its final value until next start.

## Timing
- Reset values: busy=0, done=0, all shake_* outputs 0, sample_in_ready=0, Rho_prime_raddr=0, poly_idx=0, state IDLE.
- Reset mid-operation aborts immediately; no done pulse.
- start during busy is ignored; start in DONE cycle ignored.
- Absorb phase with ready tied high: INIT 1 + 8×(RD+ABSORB) 16 + NONCE 1 = 18 cycles from INIT to SQZ.
- Input pulses arriving in any state other than the one that consumes them are ignored.
- shake_block_valid earliest one cycle after squeeze_req; sample_in_ready rises the cycle after shake_block_valid and falls the cycle after poly/block done.

## Configuration
- EXPANDS_CTRL_STATS_EN: defined -> adds output blk_cnt (16 bits, reset 0, cleared on accepted start, +1 per shake_block_valid accepted in WAIT_BLK, saturating at 16'hFFFF). Undefined -> port and counter absent, behaviour otherwise identical.

## Test plan
- Reset then start, NPOLY=11, ready high, each polynomial done after 1 block -> 11 INIT pulses, poly_idx 0..10, one done pulse, busy low after.
- Rho_prime words 0x0706050403020100.. in order, poly_idx=3 -> absorbed words equal memory contents for addresses 0..7, then 0x0000_0000_001F_0003 with last=1.
- shake_absorb_ready toggled 1-in-3 -> data/valid stable while stalled, no word dropped or duplicated.
- Polynomial 0 needs 3 blocks (two sample_block_done then sample_poly_done) -> exactly 3 squeeze_req pulses before next INIT; STATS build reports blk_cnt=13 for NPOLY=11.
- sample_block_done and sample_poly_done same cycle -> no squeeze_req, go to NEXT.
- reset asserted in WAIT_BLK of poly 5 -> all outputs to reset values next cycle; fresh start restarts from poly_idx 0.
